alu_operand_stage: RTL and testbench

- Upstream neighbour of the 16-bit ALU. Holds the 16 x 16-bit architectural register file and reads two source operands per instruction.
- Resolves read-after-write hazards with a per-register busy scoreboard and a writeback bypass.
- Presents input_a, input_b and op to the ALU through a valid/ready pipeline register.
- The ALU result returns on the writeback port and is written to the register file.

---
 rtl/alu_operand_stage_if.sv | 37 +++
 rtl/alu_operand_stage.sv | 108 ++++++++++
 tb/tb_alu_operand_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// Issue, writeback and ALU-side signals of the operand stage.
// master = decoder/ALU side, slave = operand stage.
interface alu_operand_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned OP_W   = 4
);
  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [ADDR_W-1:0] issue_rs;
  logic [ADDR_W-1:0] issue_rt;
  logic [ADDR_W-1:0] issue_rd;
  logic [DATA_W-1:0] issue_imm;
  logic              issue_use_imm;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [DATA_W-1:0] input_a;
  logic [DATA_W-1:0] input_b;
  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] alu_rd;

  modport master (
    output issue_valid, issue_op, issue_rs, issue_rt, issue_rd, issue_imm, issue_use_imm,
    output wb_en, wb_addr, wb_data, alu_ready,
    input  issue_ready, alu_valid, input_a, input_b, op, alu_rd
  );

  modport slave (
    input  issue_valid, issue_op, issue_rs, issue_rt, issue_rd, issue_imm, issue_use_imm,
    input  wb_en, wb_addr, wb_data, alu_ready,
    output issue_ready, alu_valid, input_a, input_b, op, alu_rd
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Register file + busy scoreboard + writeback bypass feeding the ALU
// through a single valid/ready pipeline register.
module alu_operand_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned OP_W   = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  alu_operand_stage_if.slave bus
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

  logic              wb_hit;
  logic              byp_a;
  logic              byp_b;
  logic              blk_a;
  logic              blk_b;
  logic              issue_ready_c;
  logic              accept;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  logic              alu_valid_q;
  logic [DATA_W-1:0] input_a_q;
  logic [DATA_W-1:0] input_b_q;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] alu_rd_q;

  // Hazard detection, operand resolution and busy-bit update
  always_comb begin
    wb_hit        = bus.wb_en && (bus.wb_addr != '0);
    byp_a         = wb_hit && (bus.wb_addr == bus.issue_rs);
    byp_b         = wb_hit && (bus.wb_addr == bus.issue_rt);
    blk_a         = busy[bus.issue_rs] && !byp_a;
    blk_b         = !bus.issue_use_imm && busy[bus.issue_rt] && !byp_b;
    issue_ready_c = (!alu_valid_q || bus.alu_ready) && !blk_a && !blk_b;
    accept        = bus.issue_valid && issue_ready_c;

    opnd_a = '0;
    if (bus.issue_rs != '0) begin
      opnd_a = byp_a ? bus.wb_data : regs[bus.issue_rs];
    end

    opnd_b = '0;
    if (bus.issue_use_imm) begin
      opnd_b = bus.issue_imm;
    end else if (bus.issue_rt != '0) begin
      opnd_b = byp_b ? bus.wb_data : regs[bus.issue_rt];
    end

    // Set after clear so a same-cycle re-issue to the written register stays busy
    busy_nxt = busy;
    if (wb_hit) begin
      busy_nxt[bus.wb_addr] = 1'b0;
    end
    if (accept && (bus.issue_rd != '0)) begin
      busy_nxt[bus.issue_rd] = 1'b1;
    end
  end

  // Register file and scoreboard
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wb_hit) begin
        regs[bus.wb_addr] <= bus.wb_data;
      end
      busy <= busy_nxt;
    end
  end

  // ALU-facing pipeline register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_valid_q <= 1'b0;
      input_a_q   <= '0;
      input_b_q   <= '0;
      op_q        <= '0;
      alu_rd_q    <= '0;
    end else if (accept) begin
      alu_valid_q <= 1'b1;
      input_a_q   <= opnd_a;
      input_b_q   <= opnd_b;
      op_q        <= bus.issue_op;
      alu_rd_q    <= bus.issue_rd;
    end else if (bus.alu_ready) begin
      alu_valid_q <= 1'b0;
    end
  end

  assign bus.issue_ready = issue_ready_c;
  assign bus.alu_valid   = alu_valid_q;
  assign bus.input_a     = input_a_q;
  assign bus.input_b     = input_b_q;
  assign bus.op          = op_q;
  assign bus.alu_rd      = alu_rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: vector table plus hand-written
// back-pressure and mid-operation reset sequences, outputs checked by a scoreboard.
module tb_alu_operand_stage;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned NREG   = 16;
  localparam int unsigned NVEC   = 14;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [3:0]  rd;
  } out_t;

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  rd;
    logic [15:0] imm;
    logic        ui;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        ar;
    logic        er;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  alu_operand_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) bus ();

  alu_operand_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int          checks;
  int          errors;
  logic [15:0] mregs [NREG];
  logic [15:0] mbusy;
  logic        mvalid;
  out_t        q[$];
  out_t        last;
  vec_t        vecs [NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input int v, input int op, input int rs, input int rt, input int rd,
                              input int imm, input int ui, input int we, input int wa, input int wd,
                              input int ar, input int er);
    vec_t t;
    t.v = 1'(v);   t.op = 4'(op);  t.rs = 4'(rs);  t.rt = 4'(rt);  t.rd = 4'(rd);
    t.imm = 16'(imm); t.ui = 1'(ui); t.we = 1'(we); t.wa = 4'(wa); t.wd = 16'(wd);
    t.ar = 1'(ar); t.er = 1'(er);
    return t;
  endfunction

  task automatic drive(input vec_t t);
    bus.issue_valid   = t.v;
    bus.issue_op      = t.op;
    bus.issue_rs      = t.rs;
    bus.issue_rt      = t.rt;
    bus.issue_rd      = t.rd;
    bus.issue_imm     = t.imm;
    bus.issue_use_imm = t.ui;
    bus.wb_en         = t.we;
    bus.wb_addr       = t.wa;
    bus.wb_data       = t.wd;
    bus.alu_ready     = t.ar;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(NREG); i++) mregs[i] = '0;
    mbusy  = '0;
    mvalid = 1'b0;
    q.delete();
    last = '{a: 16'h0, b: 16'h0, op: 4'h0, rd: 4'h0};
  endtask

  // One clock: compare settled outputs against the model, then advance the model across the edge
  task automatic cycle(input bit has_er, input logic er);
    logic [15:0] ra, rb;
    logic        hit, ba, bb, rdy;
    out_t        o;
    #1;
    hit = bus.wb_en && (bus.wb_addr != 4'd0);
    ba  = hit && (bus.wb_addr == bus.issue_rs);
    bb  = hit && (bus.wb_addr == bus.issue_rt);
    ra  = (bus.issue_rs == 4'd0) ? 16'h0 : (ba ? bus.wb_data : mregs[bus.issue_rs]);
    if (bus.issue_use_imm)        rb = bus.issue_imm;
    else if (bus.issue_rt == 4'd0) rb = 16'h0;
    else                           rb = bb ? bus.wb_data : mregs[bus.issue_rt];
    rdy = (!mvalid || bus.alu_ready) && !(mbusy[bus.issue_rs] && !ba)
          && !(!bus.issue_use_imm && mbusy[bus.issue_rt] && !bb);

    chk("issue_ready", 32'(bus.issue_ready), 32'(rdy));
    if (has_er) chk("issue_ready_vec", 32'(bus.issue_ready), 32'(er));
    chk("alu_valid", 32'(bus.alu_valid), 32'(mvalid));
    o = last;
    if (mvalid) begin
      if (q.size() == 0) chk("scoreboard_nonempty", 32'(q.size()), 32'd1);
      else               o = q[0];
    end
    chk("input_a", 32'(bus.input_a), 32'(o.a));
    chk("input_b", 32'(bus.input_b), 32'(o.b));
    chk("op",      32'(bus.op),      32'(o.op));
    chk("alu_rd",  32'(bus.alu_rd),  32'(o.rd));

    if (mvalid && bus.alu_ready && q.size() > 0) begin
      last   = q.pop_front();
      mvalid = 1'b0;
    end
    if (hit) begin
      mregs[bus.wb_addr] = bus.wb_data;
      mbusy[bus.wb_addr] = 1'b0;
    end
    if (bus.issue_valid && rdy) begin
      q.push_back('{a: ra, b: rb, op: bus.issue_op, rd: bus.issue_rd});
      mvalid = 1'b1;
      if (bus.issue_rd != 4'd0) mbusy[bus.issue_rd] = 1'b1;
    end
    @(negedge clock);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_clear();

    // Reset held with a live writeback and issue: nothing may change
    reset_n = 1'b0;
    drive(mk(1, 3, 1, 1, 2, 0, 0, 1, 1, 16'hBEEF, 1, 0));
    repeat (2) @(negedge clock);
    chk("rst_alu_valid", 32'(bus.alu_valid), 32'd0);
    chk("rst_input_a",   32'(bus.input_a),   32'd0);
    chk("rst_input_b",   32'(bus.input_b),   32'd0);
    chk("rst_op",        32'(bus.op),        32'd0);
    chk("rst_alu_rd",    32'(bus.alu_rd),    32'd0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    reset_n = 1'b1;
    #1 chk("rst_release_ready", 32'(bus.issue_ready), 32'd1);
    @(negedge clock);

    // v op rs rt rd imm ui we wa wd ar exp_ready
    vecs[0]  = mk(0, 0, 0, 0, 0, 0,       0, 1, 1, 16'h0001, 1, 1); // r1 = 1
    vecs[1]  = mk(1, 0, 1, 0, 2, 0,       0, 0, 0, 0,        1, 1); // basic issue, r2 busy
    vecs[2]  = mk(1, 3, 2, 0, 3, 0,       0, 0, 0, 0,        1, 0); // RAW stall on r2
    vecs[3]  = mk(1, 3, 2, 0, 3, 0,       0, 0, 0, 0,        1, 0);
    vecs[4]  = mk(1, 3, 2, 0, 3, 0,       0, 1, 2, 16'hFFFF, 1, 1); // bypass releases stall
    vecs[5]  = mk(1, 5, 1, 3, 4, 16'h8000, 1, 0, 0, 0,       1, 1); // imm ignores busy rt
    vecs[6]  = mk(0, 0, 0, 0, 0, 0,       0, 1, 0, 16'h1234, 1, 1); // write to r0 dropped
    vecs[7]  = mk(1, 7, 0, 0, 0, 0,       0, 0, 0, 0,        1, 1); // rd = 0 never busy
    vecs[8]  = mk(1, 1, 0, 0, 5, 0,       0, 0, 0, 0,        1, 1);
    vecs[9]  = mk(1, 2, 3, 3, 3, 0,       0, 1, 3, 16'h00AA, 1, 1); // set beats clear on r3
    vecs[10] = mk(1, 2, 3, 0, 6, 0,       0, 0, 0, 0,        1, 0);
    vecs[11] = mk(1, 2, 3, 0, 6, 0,       0, 1, 3, 16'h5555, 1, 1);
    vecs[12] = mk(1, 9, 4, 6, 7, 0,       0, 1, 4, 16'h0F0F, 1, 0); // rt busy blocks
    vecs[13] = mk(1, 9, 4, 6, 7, 0,       0, 1, 6, 16'h1111, 1, 1); // rt bypassed
    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i]);
      cycle(1'b1, vecs[i].er);
    end

    // Back-pressure: held outputs for three cycles, then accept on the release cycle
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    cycle(1'b0, 1'b0);
    drive(mk(1, 4, 1, 1, 8, 0, 0, 0, 0, 0, 0, 1));
    cycle(1'b1, 1'b1);
    drive(mk(1, 6, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) cycle(1'b1, 1'b0);
    drive(mk(1, 6, 1, 1, 9, 0, 0, 0, 0, 0, 1, 1));
    cycle(1'b1, 1'b1);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    repeat (2) cycle(1'b0, 1'b0);

    // Reset mid-operation discards the in-flight instruction and clears busy bits
    drive(mk(1, 8, 1, 1, 10, 0, 0, 0, 0, 0, 0, 1));
    cycle(1'b1, 1'b1);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_alu_valid", 32'(bus.alu_valid), 32'd0);
    chk("midrst_input_a",   32'(bus.input_a),   32'd0);
    chk("midrst_alu_rd",    32'(bus.alu_rd),    32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    model_clear();
    drive(mk(1, 2, 10, 1, 11, 0, 0, 0, 0, 0, 1, 1));
    cycle(1'b1, 1'b1);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    repeat (2) cycle(1'b0, 1'b0);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1, "timeout");
  end

endmodule
